multicycle_ctrl: RTL and testbench

Parametrised multicycle RV32I control FSM, successor to the fixed-latency controller. Sequences fetch/decode/execute/memory/writeback for the datapath. Adds:
- a variable-latency memory handshake with bus timeout,
- full six-condition branch resolution,
- an illegal-instruction/timeout trap state,
- optional performance counters.

---
 rtl/multicycle_ctrl.sv | 250 +++++++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multicycle RV32I control FSM. It steps each instruction
// through fetch/decode/execute/memory/writeback for the datapath. Memory
// accesses use a variable-latency handshake with a bus timeout. Illegal
// instructions, bus timeouts and ECALL/EBREAK halt the core in TRAP.
// Optional feature: define CTRL_PERF_CNT_EN to get the cycle and instret
// counters. Without it, those ports are tied to zero.

package multicycle_ctrl_pkg;
  typedef enum logic {ADDR_PC, ADDR_RESULT} mem_addr_sel_t;
  typedef enum logic {FETCH_INST, MEM_FUNCT_DEFINED} mem_funct3_sel_t;
  typedef enum logic [1:0] {RS1V, PC, PC_OLD} alu_src1_sel_t;
  typedef enum logic [1:0] {RS2V, IMM, PC_INC} alu_src2_sel_t;
  typedef enum logic [1:0] {ZERO, ALU_RESULT, ALU_CLOCKED, MEM_RD} result_sel_t;
  typedef enum logic [1:0] {ADD_OP, SUB_OP, FUNCT_DEFINED, SRC2_OP} alu_ops_t;
endpackage

module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [6:0]      opcode,
  input  logic [2:0]      funct3,
  input  logic            alu_zero,
  input  logic            alu_lt,
  input  logic            alu_ltu,
  input  logic            mem_ready,
  output logic            mem_req,
  output logic            branch,
  output logic            pc_update,
  output logic            inst_en,
  output logic            reg_wren,
  output logic            mem_wren,
  output mem_addr_sel_t   mem_addr_sel,
  output mem_funct3_sel_t mem_funct3_sel,
  output alu_src1_sel_t   alu_src1_sel,
  output alu_src2_sel_t   alu_src2_sel,
  output result_sel_t     result_sel,
  output alu_ops_t        alu_op,
  output logic            trap,
  output logic [1:0]      trap_cause,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [1:0] CAUSE_ILL = 2'b01;
  localparam logic [1:0] CAUSE_BUS = 2'b10;
  localparam logic [1:0] CAUSE_SYS = 2'b11;

  // Wide enough to hold MEM_TIMEOUT-1, the last count before a trap.
  localparam int WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);

  typedef enum logic [3:0] {
    FETCH, DECODE, MEM_ADDR, EXEC_R, EXEC_I, EXEC_LUI, MEM_READ,
    MEM_WRITE, MEM_WB, ALU_WB, BRANCH, JUMP, TRAP
  } state_t;

  state_t            state_q;
  logic [1:0]        cause_q;
  logic [WAIT_W-1:0] wait_q;

  logic timeout_hit;
  logic branch_ok;
  logic branch_cond;

  // The limit is reached on the MEM_TIMEOUT-th consecutive wait cycle.
  // A zero limit turns the timeout off.
  assign timeout_hit = (MEM_TIMEOUT != 0) && (wait_q == WAIT_W'(MEM_TIMEOUT - 1));

  // funct3 010/011 are not branch encodings. The others pick a flag, and
  // bit 0 inverts it.
  assign branch_ok   = (funct3[2:1] != 2'b01);
  assign branch_cond = (funct3[2] ? (funct3[1] ? alu_ltu : alu_lt) : alu_zero) ^ funct3[0];

  // State sequencing, trap-cause capture and memory wait counting.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FETCH;
      cause_q <= 2'b00;
      wait_q  <= '0;
    end else begin
      wait_q <= '0;
      case (state_q)
        FETCH, MEM_READ, MEM_WRITE: begin
          if (mem_ready) begin
            if (state_q == FETCH)         state_q <= DECODE;
            else if (state_q == MEM_READ) state_q <= MEM_WB;
            else                          state_q <= FETCH;
          end else if (timeout_hit) begin
            state_q <= TRAP;
            cause_q <= CAUSE_BUS;
          end else begin
            wait_q <= wait_q + WAIT_W'(1);
          end
        end
        DECODE: begin
          case (opcode)
            OP_R:              state_q <= EXEC_R;
            OP_I:              state_q <= EXEC_I;
            OP_LUI:            state_q <= EXEC_LUI;
            OP_AUIPC:          state_q <= ALU_WB;
            OP_LOAD, OP_STORE: state_q <= MEM_ADDR;
            OP_BRANCH:         state_q <= BRANCH;
            OP_JAL, OP_JALR:   state_q <= JUMP;
            OP_SYSTEM: begin
              state_q <= TRAP;
              cause_q <= CAUSE_SYS;
            end
            default: begin
              state_q <= TRAP;
              cause_q <= CAUSE_ILL;
            end
          endcase
        end
        MEM_ADDR: state_q <= (opcode == OP_STORE) ? MEM_WRITE : MEM_READ;
        EXEC_R, EXEC_I, EXEC_LUI, JUMP: state_q <= ALU_WB;
        MEM_WB, ALU_WB: state_q <= FETCH;
        BRANCH: begin
          if (branch_ok) begin
            state_q <= FETCH;
          end else begin
            state_q <= TRAP;
            cause_q <= CAUSE_ILL;
          end
        end
        default: state_q <= TRAP;
      endcase
    end
  end

  // Moore decode of the state, plus handshake/flag qualification.
  // Reset forces the idle FETCH view.
  always_comb begin
    mem_req        = 1'b0;
    branch         = 1'b0;
    pc_update      = 1'b0;
    inst_en        = 1'b0;
    reg_wren       = 1'b0;
    mem_wren       = 1'b0;
    trap           = 1'b0;
    mem_addr_sel   = ADDR_PC;
    mem_funct3_sel = FETCH_INST;
    alu_src1_sel   = RS1V;
    alu_src2_sel   = RS2V;
    result_sel     = ZERO;
    alu_op         = ADD_OP;
    if (reset) begin
      alu_src1_sel = PC;
      alu_src2_sel = PC_INC;
      result_sel   = ALU_RESULT;
    end else begin
      case (state_q)
        FETCH: begin
          mem_req      = 1'b1;
          alu_src1_sel = PC;
          alu_src2_sel = PC_INC;
          result_sel   = ALU_RESULT;
          inst_en      = mem_ready;
          pc_update    = mem_ready;
        end
        DECODE: begin
          alu_src1_sel = (opcode == OP_JALR) ? RS1V : PC_OLD;
          alu_src2_sel = IMM;
        end
        MEM_ADDR: alu_src2_sel = IMM;
        EXEC_R:   alu_op = FUNCT_DEFINED;
        EXEC_I: begin
          alu_src2_sel = IMM;
          alu_op       = FUNCT_DEFINED;
        end
        EXEC_LUI: begin
          alu_src2_sel = IMM;
          alu_op       = SRC2_OP;
        end
        MEM_READ, MEM_WRITE: begin
          mem_req        = 1'b1;
          mem_addr_sel   = ADDR_RESULT;
          mem_funct3_sel = MEM_FUNCT_DEFINED;
          result_sel     = ALU_CLOCKED;
          mem_wren       = (state_q == MEM_WRITE);
        end
        MEM_WB: begin
          result_sel = MEM_RD;
          reg_wren   = 1'b1;
        end
        ALU_WB: begin
          result_sel = ALU_CLOCKED;
          reg_wren   = 1'b1;
        end
        BRANCH: begin
          alu_op = SUB_OP;
          branch = branch_ok && branch_cond;
        end
        JUMP: begin
          alu_src1_sel = PC_OLD;
          alu_src2_sel = PC_INC;
          result_sel   = ALU_CLOCKED;
          pc_update    = 1'b1;
        end
        TRAP:    trap = 1'b1;
        default: ;
      endcase
    end
  end

  assign trap_cause = reset ? 2'b00 : cause_q;

`ifdef CTRL_PERF_CNT_EN
  logic [CNT_W-1:0] cycle_q;
  logic [CNT_W-1:0] instret_q;
  logic             retire;

  // An instruction retires on the step from its last state back to FETCH.
  assign retire = (state_q == MEM_WB) || (state_q == ALU_WB) ||
                  ((state_q == MEM_WRITE) && mem_ready) ||
                  ((state_q == BRANCH) && branch_ok);

  // Free-running cycle and retirement counters; both wrap naturally.
  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_q   <= '0;
      instret_q <= '0;
    end else begin
      cycle_q <= cycle_q + CNT_W'(1);
      if (retire) instret_q <= instret_q + CNT_W'(1);
    end
  end

  assign cycle_cnt   = reset ? '0 : cycle_q;
  assign instret_cnt = reset ? '0 : instret_q;
`else
  assign cycle_cnt   = '0;
  assign instret_cnt = '0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl (MEM_TIMEOUT=4, CNT_W=4). Counter
// expectations follow whether CTRL_PERF_CNT_EN is defined.
module tb_multicycle_ctrl;
  import multicycle_ctrl_pkg::*;

  logic            clk = 1'b0;
  logic            reset;
  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic            alu_zero, alu_lt, alu_ltu, mem_ready;
  logic            mem_req, branch, pc_update, inst_en, reg_wren, mem_wren, trap;
  mem_addr_sel_t   mem_addr_sel;
  mem_funct3_sel_t mem_funct3_sel;
  alu_src1_sel_t   alu_src1_sel;
  alu_src2_sel_t   alu_src2_sel;
  result_sel_t     result_sel;
  alu_ops_t        alu_op;
  logic [1:0]      trap_cause;
  logic [3:0]      cycle_cnt, instret_cnt;

  int n_cmp = 0;
  int n_bad = 0;

`ifdef CTRL_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  always #5 clk = ~clk;

  multicycle_ctrl #(.MEM_TIMEOUT(4), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3),
    .alu_zero(alu_zero), .alu_lt(alu_lt), .alu_ltu(alu_ltu),
    .mem_ready(mem_ready), .mem_req(mem_req), .branch(branch),
    .pc_update(pc_update), .inst_en(inst_en), .reg_wren(reg_wren),
    .mem_wren(mem_wren), .mem_addr_sel(mem_addr_sel),
    .mem_funct3_sel(mem_funct3_sel), .alu_src1_sel(alu_src1_sel),
    .alu_src2_sel(alu_src2_sel), .result_sel(result_sel), .alu_op(alu_op),
    .trap(trap), .trap_cause(trap_cause), .cycle_cnt(cycle_cnt),
    .instret_cnt(instret_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_cmp++;
    assert (obs === want) else begin
      n_bad++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, want);
    end
  endtask

  function automatic logic [3:0] cnt(input int v);
    return PERF ? 4'(v) : 4'd0;
  endfunction

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; opcode = 7'b0010011; funct3 = 3'b000;
    alu_zero = 1'b0; alu_lt = 1'b0; alu_ltu = 1'b0; mem_ready = 1'b0;
    next(); next();
    #1;
    chk("rst_mem_req", mem_req, 0);
    chk("rst_inst_en", inst_en, 0);
    chk("rst_trap", trap, 0);
    chk("rst_cause", trap_cause, 0);
    chk("rst_src1", alu_src1_sel, PC);
    chk("rst_result", result_sel, ALU_RESULT);
    chk("rst_cycle", cycle_cnt, 0);

    // ADDI, zero-wait memory
    reset = 1'b0; mem_ready = 1'b1;
    #1;
    chk("addi_f_req", mem_req, 1);
    chk("addi_f_inst_en", inst_en, 1);
    chk("addi_f_pc_upd", pc_update, 1);
    chk("addi_f_wren", reg_wren, 0);
    chk("addi_f_cycle", cycle_cnt, 0);
    next(); #1;
    chk("addi_d_src1", alu_src1_sel, PC_OLD);
    chk("addi_d_src2", alu_src2_sel, IMM);
    chk("addi_d_req", mem_req, 0);
    chk("addi_d_wren", reg_wren, 0);
    next(); #1;
    chk("addi_x_op", alu_op, FUNCT_DEFINED);
    chk("addi_x_src2", alu_src2_sel, IMM);
    chk("addi_x_wren", reg_wren, 0);
    next(); #1;
    chk("addi_wb_wren", reg_wren, 1);
    chk("addi_wb_res", result_sel, ALU_CLOCKED);
    chk("addi_wb_instret", instret_cnt, 0);
    next(); #1;
    chk("addi_next_req", mem_req, 1);
    chk("addi_next_wren", reg_wren, 0);
    chk("addi_instret", instret_cnt, cnt(1));
    chk("addi_cycle", cycle_cnt, cnt(4));

    // LW with three wait cycles in MEM_READ
    opcode = 7'b0000011;
    next(); #1;
    chk("lw_d_src1", alu_src1_sel, PC_OLD);
    next(); #1;
    chk("lw_a_src2", alu_src2_sel, IMM);
    chk("lw_a_req", mem_req, 0);
    next();
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("lw_wait_req", mem_req, 1);
      chk("lw_wait_addr", mem_addr_sel, ADDR_RESULT);
      chk("lw_wait_inst_en", inst_en, 0);
      next();
    end
    mem_ready = 1'b1;
    #1;
    chk("lw_done_req", mem_req, 1);
    chk("lw_done_wren", mem_wren, 0);
    next(); #1;
    chk("lw_wb_wren", reg_wren, 1);
    chk("lw_wb_res", result_sel, MEM_RD);
    chk("lw_wb_req", mem_req, 0);
    next(); #1;
    chk("lw_next_req", mem_req, 1);
    chk("lw_instret", instret_cnt, cnt(2));
    chk("lw_cycle", cycle_cnt, cnt(12));

    // BLT taken
    opcode = 7'b1100011; funct3 = 3'b100; alu_lt = 1'b1; alu_ltu = 1'b0; alu_zero = 1'b0;
    next(); next(); #1;
    chk("blt_branch", branch, 1);
    chk("blt_op", alu_op, SUB_OP);
    next(); #1;
    chk("blt_next_req", mem_req, 1);
    chk("blt_next_branch", branch, 0);
    chk("blt_instret", instret_cnt, cnt(3));
    chk("blt_cycle", cycle_cnt, cnt(15));

    // BGEU with ltu=1: not taken; the 4-bit cycle counter wraps past 15
    funct3 = 3'b111; alu_lt = 1'b0; alu_ltu = 1'b1;
    next(); next(); #1;
    chk("bgeu_branch", branch, 0);
    next(); #1;
    chk("bgeu_cycle_wrap", cycle_cnt, cnt(18));
    chk("bgeu_instret", instret_cnt, cnt(4));

    // BEQ with zero=1: taken
    funct3 = 3'b000; alu_zero = 1'b1; alu_ltu = 1'b0;
    next(); next(); #1;
    chk("beq_branch", branch, 1);
    next(); #1;
    chk("beq_instret", instret_cnt, cnt(5));

    // funct3 010 is not a branch: trap, cause 01
    funct3 = 3'b010; alu_zero = 1'b1; alu_lt = 1'b1;
    next(); next(); #1;
    chk("bill_branch", branch, 0);
    next(); #1;
    chk("bill_trap", trap, 1);
    chk("bill_cause", trap_cause, 2'b01);
    chk("bill_req", mem_req, 0);
    chk("bill_cycle", cycle_cnt, cnt(24));
    chk("bill_instret", instret_cnt, cnt(5));
    next(); #1;
    chk("bill_hold_trap", trap, 1);
    chk("bill_hold_inst_en", inst_en, 0);

    // Reset clears the trap view in the same cycle
    reset = 1'b1;
    #1;
    chk("trst_trap", trap, 0);
    chk("trst_cause", trap_cause, 0);
    chk("trst_req", mem_req, 0);
    next();
    reset = 1'b0; mem_ready = 1'b0; alu_zero = 1'b0; alu_lt = 1'b0;

    // Bus timeout in FETCH after 4 wait cycles
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("to_wait_req", mem_req, 1);
      chk("to_wait_inst_en", inst_en, 0);
      next();
    end
    #1;
    chk("to_trap", trap, 1);
    chk("to_cause", trap_cause, 2'b10);
    chk("to_req", mem_req, 0);
    mem_ready = 1'b1;
    next(); #1;
    chk("to_stay1", trap, 1);
    next(); #1;
    chk("to_stay2", trap, 1);
    chk("to_stay_req", mem_req, 0);

    // mem_ready on the 4th wait cycle wins over the timeout
    reset = 1'b1;
    next();
    reset = 1'b0; mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("late_wait_req", mem_req, 1);
      next();
    end
    mem_ready = 1'b1;
    #1;
    chk("late_inst_en", inst_en, 1);
    chk("late_trap", trap, 0);
    opcode = 7'b0000000;
    next(); #1;
    chk("late_decode_req", mem_req, 0);
    chk("late_decode_trap", trap, 0);
    chk("late_decode_src2", alu_src2_sel, IMM);
    next(); #1;
    chk("opc0_trap", trap, 1);
    chk("opc0_cause", trap_cause, 2'b01);

    // ECALL
    reset = 1'b1;
    next();
    reset = 1'b0; opcode = 7'b1110011;
    #1;
    chk("ecall_f_req", mem_req, 1);
    next(); next(); #1;
    chk("ecall_trap", trap, 1);
    chk("ecall_cause", trap_cause, 2'b11);

    // Reset in the middle of a store wait
    reset = 1'b1;
    next();
    reset = 1'b0; opcode = 7'b0100011;
    #1;
    chk("sw_restart_req", mem_req, 1);
    chk("sw_restart_trap", trap, 0);
    chk("sw_restart_cycle", cycle_cnt, 0);
    next(); next(); next();
    mem_ready = 1'b0;
    #1;
    chk("sw_wait_wren", mem_wren, 1);
    chk("sw_wait_req", mem_req, 1);
    next();
    reset = 1'b1;
    #1;
    chk("sw_rst_wren", mem_wren, 0);
    chk("sw_rst_req", mem_req, 0);
    next();
    reset = 1'b0; mem_ready = 1'b1;
    #1;
    chk("sw_after_req", mem_req, 1);
    chk("sw_after_wren", mem_wren, 0);
    chk("sw_after_inst_en", inst_en, 1);

    // JAL, then JALR decode operand
    opcode = 7'b1101111;
    next(); #1;
    chk("jal_d_src1", alu_src1_sel, PC_OLD);
    next(); #1;
    chk("jal_j_pc_upd", pc_update, 1);
    chk("jal_j_src1", alu_src1_sel, PC_OLD);
    chk("jal_j_src2", alu_src2_sel, PC_INC);
    chk("jal_j_wren", reg_wren, 0);
    next(); #1;
    chk("jal_wb_wren", reg_wren, 1);
    next(); #1;
    chk("jal_next_req", mem_req, 1);
    chk("jal_instret", instret_cnt, cnt(1));
    chk("jal_cycle", cycle_cnt, cnt(4));
    opcode = 7'b1100111;
    next(); #1;
    chk("jalr_d_src1", alu_src1_sel, RS1V);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
